// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB).
// Instruction and data memories are reached through req/ready handshakes, so
// either memory may insert wait states.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   inst_req/addr        fetch request and word address (pc[IM_AW+1:2])
//   inst_ready/rdata     fetch accepted, instruction word valid same cycle
//   dm_req/we/be/addr    data request, store flag, byte enables, aligned address
//   dm_wdata             store data
//   dm_ready/rdata       data access complete, load data valid same cycle
//   rf_addr/rf_data      debug register read port
//   cpu_pc/inst/state    PC of instruction in flight, IR, FSM state
//
// Optional build macro MULTI_CYCLE_CPU_PERF_EN adds perf_cycles and
// perf_retired counters.
module multi_cycle_cpu #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          IM_AW      = 10,
    parameter int          DM_AW      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_req,
    output logic [IM_AW-1:0] inst_addr,
    input  logic             inst_ready,
    input  logic [31:0]      inst_rdata,
    output logic             dm_req,
    output logic             dm_we,
    output logic [3:0]       dm_be,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic             dm_ready,
    input  logic [31:0]      dm_rdata,
    input  logic [4:0]       rf_addr,
    output logic [31:0]      rf_data,
    output logic [31:0]      cpu_pc,
    output logic [31:0]      cpu_inst,
    output logic [2:0]       cpu_state
`ifdef MULTI_CYCLE_CPU_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        A_ADD, A_SUB, A_SLT, A_SLTU, A_AND, A_OR, A_XOR, A_NOR, A_SLL, A_SRL, A_SRA, A_LUI
    } alu_op_e;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE, C_BR, C_JMP, C_LINK
    } cls_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_cur_q, ir_q, a_q, b_q, aluout_q, mdr_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa, dst;
    cls_e        cls;
    alu_op_e     aop;
    logic        use_imm, var_sh, zext_imm, br_taken, jump_reg, pc_load, rf_we;
    logic [31:0] imm, alu_y, alu_res, br_tgt, pc_tgt, wb_data;

    function automatic logic [31:0] alu(input alu_op_e f, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
        case (f)
            A_ADD:   return x + y;
            A_SUB:   return x - y;
            A_SLT:   return {31'd0, $signed(x) < $signed(y)};
            A_SLTU:  return {31'd0, x < y};
            A_AND:   return x & y;
            A_OR:    return x | y;
            A_XOR:   return x ^ y;
            A_NOR:   return ~(x | y);
            A_SLL:   return y << sh;
            A_SRL:   return y >> sh;
            A_SRA:   return $signed(y) >>> sh;
            A_LUI:   return {y[15:0], 16'h0000};
            default: return x + y;
        endcase
    endfunction

    // Byte loads pick the lane from the low address bits (little-endian).
    function automatic logic [31:0] load_ext(input logic [5:0] opc, input logic [31:0] w,
                                             input logic [1:0] lane);
        logic [31:0] shifted;
        shifted = w >> {lane, 3'b000};
        case (opc)
            6'h20:   return {{24{shifted[7]}}, shifted[7:0]};
            6'h24:   return {24'h0, shifted[7:0]};
            default: return w;
        endcase
    endfunction

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign sa    = ir_q[10:6];
    assign funct = ir_q[5:0];

    // Instruction decode; branch conditions use the A/B latched in DECODE.
    always_comb begin
        cls      = C_NOP;
        aop      = A_ADD;
        use_imm  = 1'b0;
        var_sh   = 1'b0;
        zext_imm = 1'b0;
        br_taken = 1'b0;
        jump_reg = 1'b0;
        dst      = rt;
        case (op)
            6'h00: begin
                dst = rd;
                cls = C_ALU;
                case (funct)
                    6'h21: aop = A_ADD;
                    6'h23: aop = A_SUB;
                    6'h2A: aop = A_SLT;
                    6'h2B: aop = A_SLTU;
                    6'h24: aop = A_AND;
                    6'h25: aop = A_OR;
                    6'h26: aop = A_XOR;
                    6'h27: aop = A_NOR;
                    6'h00: aop = A_SLL;
                    6'h02: aop = A_SRL;
                    6'h03: aop = A_SRA;
                    6'h04: begin aop = A_SLL; var_sh = 1'b1; end
                    6'h06: begin aop = A_SRL; var_sh = 1'b1; end
                    6'h07: begin aop = A_SRA; var_sh = 1'b1; end
                    6'h08: begin cls = C_JMP;  jump_reg = 1'b1; end
                    6'h09: begin cls = C_LINK; jump_reg = 1'b1; end
                    default: cls = C_NOP;
                endcase
            end
            6'h01: begin
                cls = C_BR;
                case (rt)
                    5'd0:    br_taken = a_q[31];
                    5'd1:    br_taken = !a_q[31];
                    default: cls = C_NOP;
                endcase
            end
            6'h02: cls = C_JMP;
            6'h03: begin cls = C_LINK; dst = 5'd31; end
            6'h04: begin cls = C_BR; br_taken = (a_q == b_q); end
            6'h05: begin cls = C_BR; br_taken = (a_q != b_q); end
            6'h06: begin cls = C_BR; br_taken = a_q[31] || (a_q == 32'd0); end
            6'h07: begin cls = C_BR; br_taken = !a_q[31] && (a_q != 32'd0); end
            6'h09: begin cls = C_ALU; use_imm = 1'b1; aop = A_ADD; end
            6'h0A: begin cls = C_ALU; use_imm = 1'b1; aop = A_SLT; end
            6'h0B: begin cls = C_ALU; use_imm = 1'b1; aop = A_SLTU; end
            6'h0C: begin cls = C_ALU; use_imm = 1'b1; aop = A_AND; zext_imm = 1'b1; end
            6'h0D: begin cls = C_ALU; use_imm = 1'b1; aop = A_OR;  zext_imm = 1'b1; end
            6'h0E: begin cls = C_ALU; use_imm = 1'b1; aop = A_XOR; zext_imm = 1'b1; end
            6'h0F: begin cls = C_ALU; use_imm = 1'b1; aop = A_LUI; end
            6'h20, 6'h23, 6'h24: begin cls = C_LOAD;  use_imm = 1'b1; end
            6'h28, 6'h2B:        begin cls = C_STORE; use_imm = 1'b1; end
            default: cls = C_NOP;
        endcase
    end

    assign imm     = zext_imm ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
    assign alu_y   = use_imm ? imm : b_q;
    assign alu_res = alu(aop, a_q, alu_y, var_sh ? a_q[4:0] : sa);
    // pc_q already holds the address after the branch during EXEC.
    assign br_tgt  = pc_q + {imm[29:0], 2'b00};
    assign pc_tgt  = (cls == C_BR) ? br_tgt :
                     jump_reg      ? a_q    : {pc_q[31:28], ir_q[25:0], 2'b00};
    assign pc_load = (cls == C_BR) ? br_taken : ((cls == C_JMP) || (cls == C_LINK));
    assign wb_data = (cls == C_LOAD) ? load_ext(op, mdr_q, aluout_q[1:0]) : aluout_q;
    assign rf_we   = resetn && (state_q == S_WB) && (dst != 5'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (inst_ready) state_d = S_DECODE;
            S_DECODE: state_d = (cls == C_NOP) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_ALU, C_LINK:   state_d = S_WB;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM:    if (dm_ready) state_d = (cls == C_STORE) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs; requests are also gated by resetn so nothing is asserted
    // while reset is held.
    always_comb begin
        inst_req = resetn && (state_q == S_FETCH);
        dm_req   = resetn && (state_q == S_MEM);
        dm_we    = dm_req && (cls == C_STORE);
        dm_be    = 4'h0;
        if (dm_we) dm_be = (op == 6'h2B) ? 4'hF : (4'b0001 << aluout_q[1:0]);
        dm_wdata = (op == 6'h2B) ? b_q : {4{b_q[7:0]}};
    end

    assign inst_addr = pc_q[IM_AW+1:2];
    assign dm_addr   = {aluout_q[DM_AW-1:2], 2'b00};
    assign rf_data   = (rf_addr == 5'd0) ? 32'd0 : rf_q[rf_addr];
    assign cpu_pc    = pc_cur_q;
    assign cpu_inst  = ir_q;
    assign cpu_state = state_q;

    // PC and IR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q     <= START_ADDR;
            pc_cur_q <= START_ADDR;
            ir_q     <= 32'd0;
        end else if (state_q == S_FETCH && inst_ready) begin
            ir_q     <= inst_rdata;
            pc_cur_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
        end else if (state_q == S_EXEC && pc_load) begin
            pc_q     <= pc_tgt;
        end
    end

    // Operand, ALU result and memory data registers.
    always_ff @(posedge clk) begin
        if (state_q == S_DECODE) begin
            a_q <= (rs == 5'd0) ? 32'd0 : rf_q[rs];
            b_q <= (rt == 5'd0) ? 32'd0 : rf_q[rt];
        end
        if (state_q == S_EXEC) aluout_q <= (cls == C_LINK) ? pc_cur_q + 32'd8 : alu_res;
        if (state_q == S_MEM && dm_ready) mdr_q <= dm_rdata;
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[dst] <= wb_data;
    end

`ifdef MULTI_CYCLE_CPU_PERF_EN
    logic [31:0] perf_cycles_q, perf_retired_q;

    // Any entry into FETCH from another state marks a completed instruction.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_cycles_q  <= 32'd0;
            perf_retired_q <= 32'd0;
        end else begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state_d == S_FETCH && state_q != S_FETCH)
                perf_retired_q <= perf_retired_q + 32'd1;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: table-driven ALU program plus short
// hand-written sequences for fetch stalls, byte/word memory access, reset
// during MEM, branches and jumps.
module tb_multi_cycle_cpu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_ready;
    logic [9:0]  inst_addr;
    logic [31:0] inst_rdata;
    logic        dm_req, dm_we, dm_ready;
    logic [3:0]  dm_be;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, cpu_pc, cpu_inst;
    logic [2:0]  cpu_state;
`ifdef MULTI_CYCLE_CPU_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    always #5 clk = ~clk;

    multi_cycle_cpu dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_state(cpu_state)
`ifdef MULTI_CYCLE_CPU_PERF_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    logic [31:0] imem [1024];
    logic [31:0] dmem [64];
    int istall, dstall, icnt, dcnt;
    int checks, errors;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tv [21];

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] f_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        rf_addr = r;
        #1;
        chk(name, {32'd0, rf_data}, {32'd0, exp});
    endtask

    // Memory model: ready after istall/dstall wait cycles of a pending request.
    task automatic drive_mem();
        inst_ready = inst_req && (icnt >= istall);
        inst_rdata = imem[inst_addr];
        dm_ready   = dm_req && (dcnt >= dstall);
        dm_rdata   = dmem[dm_addr[7:2]];
    endtask

    task automatic tick();
        logic        wr, iw, dw;
        logic [5:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        wr = dm_req && dm_ready && dm_we;
        wa = dm_addr[7:2];
        be = dm_be;
        wd = dm_wdata;
        iw = inst_req && !inst_ready;
        dw = dm_req && !dm_ready;
        @(posedge clk);
        if (wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) dmem[wa][8*i +: 8] = wd[8*i +: 8];
        icnt = iw ? icnt + 1 : 0;
        dcnt = dw ? dcnt + 1 : 0;
        #1;
        drive_mem();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_reset(input logic v);
        resetn = v;
        #1;
        drive_mem();
    endtask

    task automatic do_reset();
        set_reset(1'b0);
        ticks(2);
        set_reset(1'b1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
    endtask

    initial begin
        checks = 0; errors = 0;
        istall = 0; dstall = 0; icnt = 0; dcnt = 0;
        rf_addr = 5'd0;
        resetn = 1'b0;
        inst_ready = 1'b0; inst_rdata = 32'd0; dm_ready = 1'b0; dm_rdata = 32'd0;
        clear_mem();

        // ---------------- table-driven ALU program ----------------
        tv[0]  = '{f_i(6'h09, 5'd0, 5'd1, 16'd5),        5'd1,  32'd5};
        tv[1]  = '{f_i(6'h09, 5'd1, 5'd2, 16'hFFFD),     5'd2,  32'd2};
        tv[2]  = '{f_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21),   5'd3,  32'd7};
        tv[3]  = '{f_i(6'h0F, 5'd0, 5'd4, 16'h1122),     5'd4,  32'h1122_0000};
        tv[4]  = '{f_i(6'h0D, 5'd4, 5'd4, 16'h3344),     5'd4,  32'h1122_3344};
        tv[5]  = '{f_r(5'd2, 5'd1, 5'd7, 5'd0, 6'h23),   5'd7,  32'hFFFF_FFFD};
        tv[6]  = '{f_r(5'd7, 5'd1, 5'd8, 5'd0, 6'h2A),   5'd8,  32'd1};
        tv[7]  = '{f_r(5'd7, 5'd1, 5'd9, 5'd0, 6'h2B),   5'd9,  32'd0};
        tv[8]  = '{f_r(5'd4, 5'd1, 5'd10, 5'd0, 6'h24),  5'd10, 32'd4};
        tv[9]  = '{f_r(5'd4, 5'd0, 5'd11, 5'd0, 6'h27),  5'd11, 32'hEEDD_CCBB};
        tv[10] = '{f_i(6'h0E, 5'd4, 5'd12, 16'hFFFF),    5'd12, 32'h1122_CCBB};
        tv[11] = '{f_i(6'h0A, 5'd7, 5'd13, 16'hFFFE),    5'd13, 32'd1};
        tv[12] = '{f_r(5'd0, 5'd7, 5'd14, 5'd1, 6'h03),  5'd14, 32'hFFFF_FFFE};
        tv[13] = '{f_r(5'd0, 5'd7, 5'd15, 5'd4, 6'h02),  5'd15, 32'h0FFF_FFFF};
        tv[14] = '{f_r(5'd1, 5'd4, 5'd16, 5'd0, 6'h04),  5'd16, 32'h2446_6880};
        tv[15] = '{f_r(5'd2, 5'd11, 5'd17, 5'd0, 6'h07), 5'd17, 32'hFBB7_732E};
        tv[16] = '{f_i(6'h0B, 5'd1, 5'd18, 16'hFFFF),    5'd18, 32'd1};
        tv[17] = '{f_r(5'd4, 5'd11, 5'd19, 5'd0, 6'h26), 5'd19, 32'hFFFF_FFFF};
        tv[18] = '{f_r(5'd1, 5'd2, 5'd20, 5'd0, 6'h25),  5'd20, 32'd7};
        tv[19] = '{f_r(5'd0, 5'd1, 5'd21, 5'd28, 6'h00), 5'd21, 32'h5000_0000};
        tv[20] = '{f_i(6'h09, 5'd1, 5'd0, 16'd5),        5'd0,  32'd0};
        for (int i = 0; i < 21; i++) imem[i] = tv[i].inst;

        set_reset(1'b0);
        ticks(2);
        chk("rst_state", {61'd0, cpu_state}, 64'd0);
        chk("rst_pc", {32'd0, cpu_pc}, 64'd0);
        chk("rst_ir", {32'd0, cpu_inst}, 64'd0);
        chk("rst_ireq", {63'd0, inst_req}, 64'd0);
        chk("rst_dm", {58'd0, dm_req, dm_we, dm_be}, 64'd0);
`ifdef MULTI_CYCLE_CPU_PERF_EN
        chk("rst_perf", {perf_cycles, perf_retired}, 64'd0);
`endif
        set_reset(1'b1);
        chk("ireq_after_rst", {63'd0, inst_req}, 64'd1);
        for (int i = 0; i < 21; i++) begin
            ticks(4);
            chk_reg($sformatf("vec%0d_reg", i), tv[i].rd, tv[i].exp);
            chk($sformatf("vec%0d_pc", i), {29'd0, cpu_state, cpu_pc}, {32'd0, 32'(i * 4)});
`ifdef MULTI_CYCLE_CPU_PERF_EN
            if (i == 2) chk("perf_after3", {perf_cycles, perf_retired}, {32'd12, 32'd3});
`endif
        end

        // ---------------- fetch wait states and undefined opcode ----------------
        clear_mem();
        imem[0] = f_i(6'h09, 5'd0, 5'd1, 16'd6);
        imem[1] = 32'hFC00_0000;
        istall = 3;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("istall%0d", k), {29'd0, inst_req, inst_addr, cpu_state, cpu_inst},
                {29'd0, 1'b1, 10'd0, 3'd0, 32'd0});
            tick();
        end
        chk("istall_ready", {63'd0, inst_ready}, 64'd1);
        tick();
        istall = 0;
        chk("istall_ir", {29'd0, cpu_state, cpu_inst}, {29'd0, 3'd1, 32'h2401_0006});
        ticks(3);
        chk_reg("istall_r1", 5'd1, 32'd6);
        ticks(2);
        chk("nop_retire", {22'd0, inst_addr, cpu_state, cpu_pc}, {22'd0, 10'd2, 3'd0, 32'd4});

        // ---------------- byte/word memory access, reset during MEM ----------------
        clear_mem();
        dmem[0]  = 32'hFFFF_FF80;
        imem[0]  = f_i(6'h0F, 5'd0, 5'd4, 16'h1122);
        imem[1]  = f_i(6'h0D, 5'd4, 5'd4, 16'h3344);
        imem[2]  = f_i(6'h28, 5'd0, 5'd4, 16'd1);
        imem[3]  = f_i(6'h20, 5'd0, 5'd5, 16'd1);
        imem[4]  = f_i(6'h24, 5'd0, 5'd6, 16'd0);
        imem[5]  = f_i(6'h2B, 5'd0, 5'd4, 16'd6);
        imem[6]  = f_i(6'h23, 5'd0, 5'd7, 16'd7);
        imem[7]  = f_i(6'h23, 5'd0, 5'd5, 16'd4);
        do_reset();
        ticks(8);
        chk_reg("mem_r4", 5'd4, 32'h1122_3344);
        dstall = 2;
        ticks(3);
        chk("sb_state", {61'd0, cpu_state}, 64'd3);
        chk("sb_be", {60'd0, dm_be}, 64'h2);
        chk("sb_wdata", {32'd0, dm_wdata}, 64'h4444_4444);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sb_bus%0d", k), {18'd0, dm_req, dm_we, dm_be, dm_addr, dm_wdata},
                {18'd0, 1'b1, 1'b1, 4'b0010, 8'd0, 32'h4444_4444});
            tick();
        end
        dstall = 0;
        chk("sb_done", {32'd0, dmem[0]}, 64'hFFFF_4480);
        ticks(5);
        chk_reg("lb_r5", 5'd5, 32'h0000_0044);
        ticks(5);
        chk_reg("lbu_r6", 5'd6, 32'h0000_0080);
        ticks(4);
        chk("sw_misaligned", {32'd0, dmem[1]}, 64'h1122_3344);
        ticks(5);
        chk_reg("lw_r7", 5'd7, 32'h1122_3344);
        dstall = 5;
        ticks(3);
        chk("lw_in_mem", {60'd0, dm_req, cpu_state}, {60'd0, 1'b1, 3'd3});
        tick();
        set_reset(1'b0);
        tick();
        chk("rst_mem_abort", {22'd0, dm_req, cpu_state, inst_addr, cpu_pc},
            {22'd0, 1'b0, 3'd0, 10'd0, 32'd0});
        set_reset(1'b1);
        dstall = 0;
        chk_reg("rst_mem_r5", 5'd5, 32'h0000_0044);

        // ---------------- branches ----------------
        clear_mem();
        imem[0] = f_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("beq_dec%0d", k), {54'd0, inst_addr}, 64'd1);
            ticks(2);
            chk($sformatf("beq_loop%0d", k), {51'd0, cpu_state, inst_addr}, 64'd0);
        end
        clear_mem();
        imem[0] = f_i(6'h05, 5'd0, 5'd0, 16'd4);
        imem[1] = f_i(6'h09, 5'd0, 5'd1, 16'd9);
        imem[2] = f_i(6'h05, 5'd1, 5'd0, 16'd2);
        imem[5] = f_i(6'h01, 5'd1, 5'd0, 16'd5);
        imem[6] = f_i(6'h01, 5'd1, 5'd1, 16'd1);
        imem[8] = f_i(6'h07, 5'd1, 5'd0, 16'hFFF8);
        do_reset();
        ticks(3);
        chk("bne_fall", {51'd0, cpu_state, inst_addr}, 64'd1);
        ticks(4);
        chk_reg("br_r1", 5'd1, 32'd9);
        ticks(3);
        chk("bne_taken", {54'd0, inst_addr}, 64'd5);
        ticks(3);
        chk("bltz_fall", {54'd0, inst_addr}, 64'd6);
        ticks(3);
        chk("bgez_taken", {54'd0, inst_addr}, 64'd8);
        ticks(3);
        chk("bgtz_back", {54'd0, inst_addr}, 64'd1);

        // ---------------- jumps ----------------
        clear_mem();
        imem[0]     = f_j(6'h02, 26'h4);
        imem[4]     = f_j(6'h03, 26'h40);
        imem[10'h40] = f_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[6]     = f_r(5'd31, 5'd0, 5'd7, 5'd0, 6'h09);
        do_reset();
        ticks(3);
        chk("j_tgt", {51'd0, cpu_state, inst_addr}, 64'd4);
        ticks(4);
        chk_reg("jal_link", 5'd31, 32'h18);
        chk("jal_tgt", {22'd0, inst_addr, cpu_pc}, {22'd0, 10'h40, 32'h10});
        ticks(3);
        chk("jr_tgt", {54'd0, inst_addr}, 64'd6);
        ticks(4);
        chk_reg("jalr_link", 5'd7, 32'h20);
        chk("jalr_tgt", {54'd0, inst_addr}, 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
